// File: rtl/data_sram_axi_bridge.sv
// SRAM-style core data port to single-outstanding AXI4-lite bridge.
// Stalls the core for the full transaction; tracks stall cycles and sticky bus errors.
module data_sram_axi_bridge #(
    parameter int unsigned CNT_W      = 32,
    parameter bit          READ_ALIGN = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             data_sram_en,
    input  logic [3:0]       data_sram_wen,
    input  logic [31:0]      data_sram_addr,
    input  logic [31:0]      data_sram_wdata,
    output logic [31:0]      data_sram_rdata,
    output logic             data_stall,
    output logic [31:0]      araddr,
    output logic             arvalid,
    input  logic             arready,
    input  logic [31:0]      rdata,
    input  logic [1:0]       rresp,
    input  logic             rvalid,
    output logic             rready,
    output logic [31:0]      awaddr,
    output logic             awvalid,
    input  logic             awready,
    output logic [31:0]      wdata,
    output logic [3:0]       wstrb,
    output logic             wvalid,
    input  logic             wready,
    input  logic [1:0]       bresp,
    input  logic             bvalid,
    output logic             bready,
    output logic             bus_error,
    output logic [CNT_W-1:0] perf_stall_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StRdAddr,
        StRdData,
        StWr,
        StWrResp,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  wen_q;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        bus_error_q;
    logic [CNT_W-1:0] cnt_q;
    logic        latch_req;
    logic        rd_capture;
    logic        resp_err;

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        latch_req = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (data_sram_en) begin
                    latch_req = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = (data_sram_wen == 4'h0) ? StRdAddr : StWr;
                end
            end
            StRdAddr: if (arready) state_d = StRdData;
            StRdData: if (rvalid) state_d = StDone;
            StWr: begin
                // aw and w retire independently; leave once both have been accepted
                if (awvalid && awready) aw_done_d = 1'b1;
                if (wvalid && wready) w_done_d = 1'b1;
                if (aw_done_d && w_done_d) state_d = StWrResp;
            end
            StWrResp: if (bvalid) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    assign rd_capture = (state_q == StRdData) && rvalid;
    assign resp_err   = (rd_capture && (rresp != 2'b00)) ||
                        ((state_q == StWrResp) && bvalid && (bresp != 2'b00));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            wen_q       <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rdata_q     <= '0;
            bus_error_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            if (latch_req) begin
                addr_q  <= data_sram_addr;
                wdata_q <= data_sram_wdata;
                wen_q   <= data_sram_wen;
            end
            if (rd_capture) rdata_q <= rdata;
            if (resp_err) bus_error_q <= 1'b1;
            if (data_stall && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign data_stall = (state_q != StDone) && ((state_q != StIdle) || data_sram_en);

    assign araddr  = READ_ALIGN ? {addr_q[31:2], 2'b00} : addr_q;
    assign arvalid = (state_q == StRdAddr);
    assign rready  = (state_q == StRdData);
    assign awaddr  = addr_q;
    assign awvalid = (state_q == StWr) && !aw_done_q;
    assign wdata   = wdata_q;
    assign wstrb   = wen_q;
    assign wvalid  = (state_q == StWr) && !w_done_q;
    assign bready  = (state_q == StWrResp);

    assign data_sram_rdata = rdata_q;
    assign bus_error       = bus_error_q;
    assign perf_stall_cnt  = cnt_q;

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Self-checking bench for data_sram_axi_bridge: delay-configurable AXI slave model,
// per-transaction scoreboard of expected read data and stall lengths.
module tb_data_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr, wdat;

    logic [31:0] sram_rdata, araddr, rdata, awaddr, wdata;
    logic [3:0]  wstrb;
    logic [1:0]  rresp, bresp;
    logic        data_stall, arvalid, arready, rvalid, rready, awvalid, awready;
    logic        wvalid, wready, bvalid, bready, bus_error;
    logic [31:0] perf_stall_cnt;

    logic [31:0] s4_sram_rdata, s4_araddr, s4_awaddr, s4_wdata;
    logic [3:0]  s4_wstrb, s4_perf;
    logic        s4_stall, s4_arvalid, s4_rready, s4_awvalid, s4_wvalid, s4_bready, s4_bus_error;

    int ar_d, r_d, aw_d, w_d, b_d;
    int ar_c, r_c, aw_c, w_c, b_c;
    int ar_hs, aw_hs, w_hs;
    logic [31:0] r_val;
    logic [1:0]  r_resp, b_resp;

    int n_checks = 0;
    int n_fail = 0;
    int exp_perf = 0;
    logic [31:0] last_rd = 32'h0;
    logic [31:0] exp_rd_q[$];
    int          exp_stall_q[$];

    always #5 clk = ~clk;

    data_sram_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .data_sram_en(en), .data_sram_wen(wen), .data_sram_addr(addr),
        .data_sram_wdata(wdat), .data_sram_rdata(sram_rdata), .data_stall(data_stall),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .bus_error(bus_error), .perf_stall_cnt(perf_stall_cnt)
    );

    // Narrow-counter twin driven by the same stimulus, used for saturation.
    data_sram_axi_bridge #(.CNT_W(4)) dut4 (
        .clk(clk), .resetn(resetn),
        .data_sram_en(en), .data_sram_wen(wen), .data_sram_addr(addr),
        .data_sram_wdata(wdat), .data_sram_rdata(s4_sram_rdata), .data_stall(s4_stall),
        .araddr(s4_araddr), .arvalid(s4_arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(s4_rready),
        .awaddr(s4_awaddr), .awvalid(s4_awvalid), .awready(awready),
        .wdata(s4_wdata), .wstrb(s4_wstrb), .wvalid(s4_wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(s4_bready),
        .bus_error(s4_bus_error), .perf_stall_cnt(s4_perf)
    );

    assign arready = arvalid && (ar_c >= ar_d);
    assign rvalid  = rready && (r_c >= r_d);
    assign awready = awvalid && (aw_c >= aw_d);
    assign wready  = wvalid && (w_c >= w_d);
    assign bvalid  = bready && (b_c >= b_d);
    assign rdata   = r_val;
    assign rresp   = r_resp;
    assign bresp   = b_resp;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_c <= 0; r_c <= 0; aw_c <= 0; w_c <= 0; b_c <= 0;
        end else begin
            ar_c <= (arvalid && !arready) ? ar_c + 1 : 0;
            r_c  <= (rready && !rvalid) ? r_c + 1 : 0;
            aw_c <= (awvalid && !awready) ? aw_c + 1 : 0;
            w_c  <= (wvalid && !wready) ? w_c + 1 : 0;
            b_c  <= (bready && !bvalid) ? b_c + 1 : 0;
        end
    end

    initial begin
        ar_hs = 0; aw_hs = 0; w_hs = 0;
    end
    always @(posedge clk) begin
        if (arvalid && arready) ar_hs <= ar_hs + 1;
        if (awvalid && awready) aw_hs <= aw_hs + 1;
        if (wvalid && wready) w_hs <= w_hs + 1;
    end

    task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                           input int ard, input int rd, input bit keep);
        int stalls, ar_cycles, ar0, exp_st;
        logic [31:0] exp_d;
        bit done;
        ar_d = ard; r_d = rd; r_val = d; r_resp = resp;
        exp_rd_q.push_back(d);
        exp_stall_q.push_back(3 + ard + rd);
        en = 1'b1; wen = 4'h0; addr = a; wdat = $urandom;
        stalls = 0; ar_cycles = 0; ar0 = ar_hs; done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (data_stall) begin
                stalls++;
                if (arvalid) begin
                    ar_cycles++;
                    n_checks++;
                    if (araddr !== {a[31:2], 2'b00}) begin
                        n_fail++;
                        $display("FAIL araddr: got %h expected %h", araddr, {a[31:2], 2'b00});
                    end
                end
                @(posedge clk); #1;
            end else begin
                done = 1'b1;
            end
        end
        exp_d  = exp_rd_q.pop_front();
        exp_st = exp_stall_q.pop_front();
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL read_timeout: got stalls %0d expected %0d", stalls, exp_st);
        end else begin
            exp_perf += exp_st;
            last_rd = exp_d;
            if (sram_rdata !== exp_d) begin
                n_fail++;
                $display("FAIL read_data: got %h expected %h", sram_rdata, exp_d);
            end
            n_checks++;
            if (stalls != exp_st) begin
                n_fail++;
                $display("FAIL read_stall: got %0d expected %0d", stalls, exp_st);
            end
            n_checks++;
            if (perf_stall_cnt !== 32'(exp_perf)) begin
                n_fail++;
                $display("FAIL read_perf: got %0d expected %0d", perf_stall_cnt, exp_perf);
            end
            n_checks++;
            if (ar_cycles != ard + 1 || ar_hs - ar0 != 1) begin
                n_fail++;
                $display("FAIL ar_hold: got %0d cycles/%0d hs expected %0d/1",
                         ar_cycles, ar_hs - ar0, ard + 1);
            end
        end
        @(posedge clk); #1;
        if (!keep) en = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] strb, input logic [31:0] d,
                            input int awd, input int wd, input int bd, input logic [1:0] resp,
                            input bit keep, output bit split_seen);
        int stalls, exp_st, aw0, w0;
        bit done;
        aw_d = awd; w_d = wd; b_d = bd; b_resp = resp;
        exp_stall_q.push_back(3 + ((awd > wd) ? awd : wd) + bd);
        en = 1'b1; wen = strb; addr = a; wdat = d;
        stalls = 0; aw0 = aw_hs; w0 = w_hs; done = 1'b0; split_seen = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (data_stall) begin
                stalls++;
                if (!awvalid && wvalid) split_seen = 1'b1;
                if (awvalid || wvalid) begin
                    n_checks++;
                    if (awaddr !== a || wstrb !== strb || wdata !== d) begin
                        n_fail++;
                        $display("FAIL write_payload: got %h/%h/%h expected %h/%h/%h",
                                 awaddr, wstrb, wdata, a, strb, d);
                    end
                end
                @(posedge clk); #1;
            end else begin
                done = 1'b1;
            end
        end
        exp_st = exp_stall_q.pop_front();
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL write_timeout: got stalls %0d expected %0d", stalls, exp_st);
        end else begin
            exp_perf += exp_st;
            if (stalls != exp_st) begin
                n_fail++;
                $display("FAIL write_stall: got %0d expected %0d", stalls, exp_st);
            end
            n_checks++;
            if (aw_hs - aw0 != 1 || w_hs - w0 != 1) begin
                n_fail++;
                $display("FAIL write_hs: got aw %0d w %0d expected 1 1", aw_hs - aw0, w_hs - w0);
            end
            n_checks++;
            if (sram_rdata !== last_rd) begin
                n_fail++;
                $display("FAIL write_keeps_rdata: got %h expected %h", sram_rdata, last_rd);
            end
            n_checks++;
            if (perf_stall_cnt !== 32'(exp_perf)) begin
                n_fail++;
                $display("FAIL write_perf: got %0d expected %0d", perf_stall_cnt, exp_perf);
            end
        end
        @(posedge clk); #1;
        if (!keep) begin
            en = 1'b0; wen = 4'h0;
        end
    endtask

    task automatic test_reset();
        en = 1'b0; wen = 4'h0; addr = '0; wdat = '0;
        ar_d = 0; r_d = 0; aw_d = 0; w_d = 0; b_d = 0;
        r_val = '0; r_resp = 2'b00; b_resp = 2'b00;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({data_stall, arvalid, rready, awvalid, wvalid, bready, bus_error} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {data_stall, arvalid, rready, awvalid, wvalid, bready, bus_error});
        end
        n_checks++;
        if (sram_rdata !== 32'h0 || perf_stall_cnt !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h expected 0/0", sram_rdata, perf_stall_cnt);
        end
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_basic();
        do_read(32'h1000_0004, 32'h1234_5678, 2'b00, 0, 0, 1'b0);
    endtask

    task automatic test_write_split();
        bit split;
        do_write(32'h8000_0006, 4'b0011, 32'hCAFE_F00D, 0, 2, 0, 2'b00, 1'b0, split);
        n_checks++;
        if (split !== 1'b1) begin
            n_fail++;
            $display("FAIL write_aw_first: got %b expected 1", split);
        end
    endtask

    task automatic test_read_slow();
        do_read(32'h2000_0013, 32'hA5A5_0F0F, 2'b00, 4, 0, 1'b0);
    endtask

    task automatic test_bus_error();
        bit split;
        n_checks++;
        if (bus_error !== 1'b0) begin
            n_fail++;
            $display("FAIL bus_error_pre: got %b expected 0", bus_error);
        end
        do_write(32'h0000_0040, 4'hF, 32'h1111_2222, 1, 0, 1, 2'b10, 1'b0, split);
        n_checks++;
        if (bus_error !== 1'b1) begin
            n_fail++;
            $display("FAIL bus_error_set: got %b expected 1", bus_error);
        end
        b_resp = 2'b00;
        do_read(32'h0000_0044, $urandom, 2'b00, 0, 1, 1'b0);
        do_write(32'h0000_0048, 4'b1100, $urandom, 0, 0, 0, 2'b00, 1'b0, split);
        do_read(32'h0000_004C, $urandom, 2'b00, 1, 0, 1'b0);
        n_checks++;
        if (bus_error !== 1'b1) begin
            n_fail++;
            $display("FAIL bus_error_sticky: got %b expected 1", bus_error);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        ar_d = 0; r_d = 50; r_resp = 2'b00;
        en = 1'b1; wen = 4'h0; addr = 32'h3000_0000;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rready) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL reset_mid_reach: got rready %b expected 1", rready);
        end
        #1 resetn = 1'b0;
        #1;
        n_checks++;
        if ({arvalid, rready, bus_error} !== 3'b000 || perf_stall_cnt !== 32'h0 ||
            s4_perf !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %b/%h/%h expected 000/0/0",
                     {arvalid, rready, bus_error}, perf_stall_cnt, s4_perf);
        end
        en = 1'b0;
        exp_perf = 0;
        r_d = 0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (data_stall !== 1'b0 || rready !== 1'b0 || sram_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_after: got %b/%b/%h expected 0/0/0",
                     data_stall, rready, sram_rdata);
        end
        last_rd = 32'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bit split;
        do_read(32'h4000_0008, 32'hDEAD_BEEF, 2'b00, 0, 0, 1'b1);
        do_write(32'h4000_000C, 4'b1000, 32'h7700_0000, 0, 0, 0, 2'b00, 1'b0, split);
    endtask

    task automatic test_saturation();
        do_read(32'h5000_0000, 32'h0BAD_F00D, 2'b00, 17, 0, 1'b0);
        n_checks++;
        if (s4_perf !== 4'hF) begin
            n_fail++;
            $display("FAIL perf_saturate: got %h expected f", s4_perf);
        end
        en = 1'b1; wen = 4'h0; addr = 32'h5000_0004;
        r_val = 32'h1; ar_d = 0; r_d = 0;
        repeat (4) @(posedge clk);
        #1 en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (s4_perf !== 4'hF) begin
            n_fail++;
            $display("FAIL perf_hold: got %h expected f", s4_perf);
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_split();
        test_read_slow();
        test_bus_error();
        test_reset_mid();
        test_back_to_back();
        test_saturation();
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
